boot_rom_if: RTL and testbench

BOOT_ROM_IF -- requirements
Module: boot_rom_if

---
 rtl/boot_rom_pkg.sv | 15 +
 rtl/boot_rom_resp_fifo.sv | 51 +++++
 rtl/boot_rom_if.sv | 114 +++++++++++
 tb/tb_boot_rom_if.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_rom_pkg.sv
// Shared constants and response type for the boot ROM interface.
// The optional error checking is enabled by defining BOOT_ROM_IF_ERR_EN.
package boot_rom_pkg;

  localparam int unsigned ROM_AW    = 10;
  localparam int unsigned ROM_WORDS = 548;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rom_resp_t;

  localparam rom_resp_t RESP_ZERO = '{data: 32'h0000_0000, err: 1'b0};

endpackage

// File: rtl/boot_rom_resp_fifo.sv
// Two-entry in-order response FIFO for the boot ROM interface.
// Callers guarantee no pop when empty and no push when full.
module boot_rom_resp_fifo
  import boot_rom_pkg::*;
(
  input  logic      CLK,
  input  logic      RSTN,
  input  logic      push,
  input  rom_resp_t push_data,
  input  logic      pop,
  output rom_resp_t head,
  output logic [1:0] count,
  output logic      full,
  output logic      empty
);

  rom_resp_t  mem_r [2];
  logic       wr_ptr_r;
  logic       rd_ptr_r;
  logic [1:0] count_r;

  // Storage, pointers and occupancy count
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      mem_r[0] <= RESP_ZERO;
      mem_r[1] <= RESP_ZERO;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == 2'd2);
  assign empty = (count_r == 2'd0);

endmodule

// File: rtl/boot_rom_if.sv
// Boot ROM request/response adapter: one-cycle flow-through reads with a 2-deep skid FIFO.
// Define BOOT_ROM_IF_ERR_EN to flag writes, misaligned and out-of-range reads as errors.
module boot_rom_if
  import boot_rom_pkg::*;
#(
  parameter int unsigned ROM_WORDS = boot_rom_pkg::ROM_WORDS,
  parameter int unsigned ROM_AW    = boot_rom_pkg::ROM_AW
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              req_i,
  output logic              gnt_o,
  input  logic [31:0]       addr_i,
  input  logic              we_i,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  output logic              rom_csn_o,
  output logic [ROM_AW-1:0] rom_a_o,
  input  logic [31:0]       rom_q_i
);

  localparam logic [31:0] ROM_WORDS_W = 32'(ROM_WORDS);

  logic [ROM_AW-1:0] word_idx_s;
  logic              req_err_s;
  logic              no_access_s;
  logic              accept_s;
  logic [1:0]        occ_s;
  logic              inflight_r;
  logic              inflight_zero_r;
  logic              inflight_err_r;
  rom_resp_t         flow_resp_s;
  rom_resp_t         fifo_head_s;
  rom_resp_t         resp_out_s;
  logic [1:0]        fifo_count_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              push_s;
  logic              pop_s;
  logic              unused_s;

  assign word_idx_s = addr_i[ROM_AW+1:2];

`ifdef BOOT_ROM_IF_ERR_EN
  assign req_err_s   = we_i | (addr_i[1:0] != 2'b00) | (32'(word_idx_s) >= ROM_WORDS_W);
  assign no_access_s = req_err_s;
`else
  // Misaligned and out-of-range reads simply use the truncated index
  assign req_err_s   = 1'b0;
  assign no_access_s = we_i;
`endif

  assign occ_s     = {1'b0, inflight_r} + fifo_count_s;
  assign gnt_o     = RSTN & req_i & (occ_s < 2'd2);
  assign accept_s  = req_i & gnt_o;
  assign rom_csn_o = ~(accept_s & ~no_access_s);
  assign rom_a_o   = RSTN ? word_idx_s : {ROM_AW{1'b0}};

  // Tracks the request whose ROM data arrives this cycle
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      inflight_r      <= 1'b0;
      inflight_zero_r <= 1'b0;
      inflight_err_r  <= 1'b0;
    end else begin
      inflight_r      <= accept_s;
      inflight_zero_r <= accept_s & no_access_s;
      inflight_err_r  <= accept_s & req_err_s;
    end
  end

  assign flow_resp_s.data = inflight_zero_r ? 32'h0000_0000 : rom_q_i;
  assign flow_resp_s.err  = inflight_err_r;

  // The in-flight response skips the FIFO only when it is empty and the consumer is ready
  assign push_s = inflight_r & ~(fifo_empty_s & rready_i);
  assign pop_s  = ~fifo_empty_s & rready_i;

  boot_rom_resp_fifo u_resp_fifo (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .push      (push_s),
    .push_data (flow_resp_s),
    .pop       (pop_s),
    .head      (fifo_head_s),
    .count     (fifo_count_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Response selection: FIFO head has priority to keep ordering
  always_comb begin
    rvalid_o   = 1'b0;
    resp_out_s = RESP_ZERO;
    if (!fifo_empty_s) begin
      rvalid_o   = 1'b1;
      resp_out_s = fifo_head_s;
    end else if (inflight_r) begin
      rvalid_o   = 1'b1;
      resp_out_s = flow_resp_s;
    end else begin
      rvalid_o   = 1'b0;
      resp_out_s = RESP_ZERO;
    end
  end

  assign rdata_o = resp_out_s.data;
  assign err_o   = resp_out_s.err;

  assign unused_s = ^{addr_i[31:ROM_AW+2], addr_i[1:0], fifo_full_s};

endmodule

// File: tb/tb_boot_rom_if.sv
// Self-checking bench for boot_rom_if: directed cases plus randomized traffic against a queue model.
// Build with BOOT_ROM_IF_ERR_EN defined to exercise the error-checking configuration.
module tb_boot_rom_if;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic        rready_i = 1'b0;
  logic [31:0] addr_i = 32'h0;
  logic [31:0] rom_q_i = 32'h0;
  logic        gnt_o, rvalid_o, err_o, rom_csn_o;
  logic [31:0] rdata_o;
  logic [9:0]  rom_a_o;

  logic [31:0] rom_mem [0:1023];
  logic [32:0] exp_q [$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  bit          chk_en = 1'b0;

  boot_rom_if dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .req_i     (req_i),
    .gnt_o     (gnt_o),
    .addr_i    (addr_i),
    .we_i      (we_i),
    .rvalid_o  (rvalid_o),
    .rready_i  (rready_i),
    .rdata_o   (rdata_o),
    .err_o     (err_o),
    .rom_csn_o (rom_csn_o),
    .rom_a_o   (rom_a_o),
    .rom_q_i   (rom_q_i)
  );

  always #5 CLK = ~CLK;

  // Synchronous ROM: data for a selected word appears next cycle and holds otherwise
  always @(posedge CLK) begin
    if (!rom_csn_o) rom_q_i <= rom_mem[rom_a_o];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic bit no_rom_access(input logic [31:0] a, input logic w);
    int idx;
    idx = int'(a[11:2]);
`ifdef BOOT_ROM_IF_ERR_EN
    return w || (a[1:0] != 2'b00) || (idx >= 548);
`else
    return w;
`endif
  endfunction

  // Expected response as {err, data}
  function automatic logic [32:0] model_resp(input logic [31:0] a, input logic w);
    int idx;
    idx = int'(a[11:2]);
`ifdef BOOT_ROM_IF_ERR_EN
    if (w || (a[1:0] != 2'b00) || (idx >= 548)) return {1'b1, 32'h0};
    return {1'b0, rom_mem[idx]};
`else
    if (w) return {1'b0, 32'h0};
    return {1'b0, rom_mem[idx]};
`endif
  endfunction

  // Model: outstanding responses in order; at most two accepted but not yet consumed
  always @(posedge CLK or negedge RSTN) begin
    bit acc;
    if (!RSTN) begin
      exp_q.delete();
    end else begin
      acc = req_i && (exp_q.size() < 2);
      if (exp_q.size() > 0 && rready_i) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(model_resp(addr_i, we_i));
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge CLK) begin
    bit exp_gnt;
    if (chk_en) begin
      if (!RSTN) begin
        check("rst_gnt", 32'(gnt_o), 32'h0);
        check("rst_rvalid", 32'(rvalid_o), 32'h0);
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_err", 32'(err_o), 32'h0);
        check("rst_csn", 32'(rom_csn_o), 32'h1);
        check("rst_rom_a", 32'(rom_a_o), 32'h0);
      end else begin
        exp_gnt = req_i && (exp_q.size() < 2);
        check("gnt", 32'(gnt_o), 32'(exp_gnt));
        check("rvalid", 32'(rvalid_o), 32'(exp_q.size() > 0));
        check("rom_a", 32'(rom_a_o), 32'(addr_i[11:2]));
        check("csn", 32'(rom_csn_o), 32'(!(exp_gnt && !no_rom_access(addr_i, we_i))));
        if (exp_q.size() > 0) begin
          check("rdata", rdata_o, exp_q[0][31:0]);
          check("err", 32'(err_o), 32'(exp_q[0][32]));
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic r, input logic [31:0] a, input logic w, input logic rr);
    req_i = r; addr_i = a; we_i = w; rready_i = rr;
  endtask

  initial begin
    logic [32:0] m;
    logic [31:0] a;
    for (int i = 0; i < 1024; i++) rom_mem[i] = (32'(i) * 32'h9E37_79B9) ^ 32'hC0DE_0000;
    rom_mem[0]   = 32'h0000_0297;
    rom_mem[1]   = 32'h0202_8593;
    rom_mem[2]   = 32'h0005_A283;
    rom_mem[31]  = 32'h0100_006F;
    rom_mem[547] = 32'h0000_0073;
    chk_en = 1'b1;

    // Model pins
    m = model_resp(32'h0000_007C, 1'b0);
    check("model_7c_data", m[31:0], 32'h0100_006F);
    check("model_7c_err", 32'(m[32]), 32'h0);
    m = model_resp(32'h0000_0010, 1'b1);
    check("model_wr_data", m[31:0], 32'h0);

    repeat (3) @(posedge CLK);
    #1 RSTN = 1'b1;

    // Single read of word 0x1F
    step(); drive(1'b1, 32'h0000_007C, 1'b0, 1'b1);
    @(negedge CLK);
    check("d33_gnt", 32'(gnt_o), 32'h1);
    check("d33_csn", 32'(rom_csn_o), 32'h0);
    check("d33_rom_a", 32'(rom_a_o), 32'h1F);
    step(); drive(1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge CLK);
    check("d33_rvalid", 32'(rvalid_o), 32'h1);
    check("d33_rdata", rdata_o, 32'h0100_006F);
    check("d33_err", 32'(err_o), 32'h0);
    step();

    // Back-to-back with consumer stalled: third request held off
    drive(1'b1, 32'h0, 1'b0, 1'b0);
    @(negedge CLK); check("d34_gnt0", 32'(gnt_o), 32'h1);
    step(); addr_i = 32'h4;
    @(negedge CLK); check("d34_gnt1", 32'(gnt_o), 32'h1);
    step(); addr_i = 32'h8;
    @(negedge CLK); check("d34_gnt2_stall", 32'(gnt_o), 32'h0);
    step();
    @(negedge CLK);
    check("d34_hold_rvalid", 32'(rvalid_o), 32'h1);
    check("d34_hold_rdata", rdata_o, 32'h0000_0297);
    step(); rready_i = 1'b1;
    @(negedge CLK);
    check("d34_r0", rdata_o, 32'h0000_0297);
    check("d34_gnt_full", 32'(gnt_o), 32'h0);
    step();
    @(negedge CLK);
    check("d34_gnt_third", 32'(gnt_o), 32'h1);
    check("d34_r1", rdata_o, 32'h0202_8593);
    step(); req_i = 1'b0;
    @(negedge CLK);
    check("d34_r2_valid", 32'(rvalid_o), 32'h1);
    check("d34_r2", rdata_o, 32'h0005_A283);
    step();
    @(negedge CLK); check("d34_idle", 32'(rvalid_o), 32'h0);

`ifdef BOOT_ROM_IF_ERR_EN
    step(); drive(1'b1, 32'h0000_0010, 1'b1, 1'b1);
    @(negedge CLK); check("d35_wr_csn", 32'(rom_csn_o), 32'h1);
    step(); drive(1'b1, 32'h0000_088C, 1'b0, 1'b1);
    @(negedge CLK);
    check("d35_wr_err", 32'(err_o), 32'h1);
    check("d35_wr_rdata", rdata_o, 32'h0);
    check("d35_547_csn", 32'(rom_csn_o), 32'h0);
    step(); drive(1'b1, 32'h0000_0890, 1'b0, 1'b1);
    @(negedge CLK);
    check("d35_547_err", 32'(err_o), 32'h0);
    check("d35_547_rdata", rdata_o, 32'h0000_0073);
    check("d35_548_csn", 32'(rom_csn_o), 32'h1);
    step(); drive(1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge CLK);
    check("d35_548_err", 32'(err_o), 32'h1);
    check("d35_548_rdata", rdata_o, 32'h0);
`else
    step(); drive(1'b1, 32'h0000_0002, 1'b0, 1'b1);
    @(negedge CLK);
    check("d36_csn", 32'(rom_csn_o), 32'h0);
    check("d36_rom_a", 32'(rom_a_o), 32'h0);
    step(); drive(1'b1, 32'h0000_0010, 1'b1, 1'b1);
    @(negedge CLK);
    check("d36_err", 32'(err_o), 32'h0);
    check("d36_rdata", rdata_o, 32'h0000_0297);
    check("d36_wr_csn", 32'(rom_csn_o), 32'h1);
    step(); drive(1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge CLK);
    check("d36_wr_err", 32'(err_o), 32'h0);
    check("d36_wr_rdata", rdata_o, 32'h0);
`endif

    // Reset while two responses are buffered
    step(); drive(1'b1, 32'h0000_0004, 1'b0, 1'b0);
    step();
    step(); req_i = 1'b0;
    @(negedge CLK);
    check("d37_pre_rvalid", 32'(rvalid_o), 32'h1);
    #3 RSTN = 1'b0;
    step(); step();
    RSTN = 1'b1; drive(1'b1, 32'h0, 1'b0, 1'b0);
    @(negedge CLK);
    check("d37_gnt", 32'(gnt_o), 32'h1);
    check("d37_rvalid", 32'(rvalid_o), 32'h0);
    step(); drive(1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge CLK);
    check("d37_fresh", rdata_o, 32'h0000_0297);
    step();
    @(negedge CLK); check("d37_no_stale", 32'(rvalid_o), 32'h0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step();
      a = $urandom;
      case ($urandom_range(0, 3))
        0: begin a[11:2] = 10'($urandom_range(0, 547)); a[1:0] = 2'b00; end
        1: a[11:2] = 10'($urandom_range(0, 547));
        2: a = $urandom;
        default: a = 32'h0000_0880 + 32'($urandom_range(0, 7) * 4);
      endcase
      drive(($urandom_range(0, 9) < 7), a, ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) < 6));
    end

    // Drain
    step(); drive(1'b0, 32'h0, 1'b0, 1'b1);
    repeat (4) step();
    @(negedge CLK); check("drain_idle", 32'(rvalid_o), 32'h0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
